xgriscv_dmem: RTL

- Data-memory responder for the pipeline's MEM-stage memory interface. It accepts the datapath's load/store request: the ALU-result address, the store data, the write enable, the size selects and the unsigned-load select.
- It returns read data in the same cycle, so the datapath needs no stall.
- Stores pass through a one-entry write buffer that commits to the array one cycle later. Loads forward any bytes still held in that buffer.
- Misaligned accesses are suppressed and flagged, with a sticky fault record for the testbench.

---
 rtl/xgriscv_dmem_if.sv | 30 +++
 rtl/xgriscv_dmem.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/xgriscv_dmem_if.sv
// MEM-stage data-memory bus: the datapath's load/store request toward the memory,
// plus read data and fault status coming back.
interface xgriscv_dmem_if #(
  parameter int XLEN = 32
);
  logic            memwriteM;
  logic            memreadM;
  logic [XLEN-1:0] aluoutM;
  logic [XLEN-1:0] writedataM;
  logic [1:0]      swhbM;
  logic [1:0]      lwhbM;
  logic            lunsignedM;
  logic [XLEN-1:0] pcM;
  logic [XLEN-1:0] readdataM;
  logic            misalignM;
  logic            faultS;
  logic [XLEN-1:0] fault_addr;
  logic [XLEN-1:0] fault_pc;
  logic [31:0]     store_cnt;

  modport master (
    output memwriteM, memreadM, aluoutM, writedataM, swhbM, lwhbM, lunsignedM, pcM,
    input  readdataM, misalignM, faultS, fault_addr, fault_pc, store_cnt
  );

  modport slave (
    input  memwriteM, memreadM, aluoutM, writedataM, swhbM, lwhbM, lunsignedM, pcM,
    output readdataM, misalignM, faultS, fault_addr, fault_pc, store_cnt
  );
endinterface

// File: rtl/xgriscv_dmem.sv
// Data memory with same-cycle load data, a one-entry store buffer that commits one
// cycle later with byte forwarding, and a sticky misalignment fault record.
module xgriscv_dmem #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input logic           clk,
  input logic           reset,
  xgriscv_dmem_if.slave bus
);

  // Size encoding: 00 word, 01 half, 10 byte, 11 word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = 1'b0;
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   byte_en = 4'b0011 << {a[1], 1'b0};
      2'b10:   byte_en = 4'b0001 << a;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  logic [XLEN-1:0] mem_q [DEPTH];

  logic            pend_valid_q, pend_valid_d;
  logic [AW-1:0]   pend_idx_q,   pend_idx_d;
  logic [3:0]      pend_be_q,    pend_be_d;
  logic [XLEN-1:0] pend_data_q,  pend_data_d;

  logic            fault_q,      fault_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic [XLEN-1:0] fault_pc_q,   fault_pc_d;
  logic [31:0]     store_cnt_q,  store_cnt_d;

  logic [AW-1:0]   idx_s;
  logic [1:0]      boff_s;
  logic            st_mis_s;
  logic            ld_mis_s;
  logic            misalign_s;
  logic            store_acc_s;
  logic [XLEN-1:0] mem_word_s;
  logic [XLEN-1:0] fwd_word_s;
  logic [XLEN-1:0] shifted_s;
  logic [XLEN-1:0] load_val_s;
  logic [XLEN-1:0] readdata_s;

  assign idx_s       = bus.aluoutM[AW+1:2];
  assign boff_s      = bus.aluoutM[1:0];
  assign st_mis_s    = bus.memwriteM & is_misaligned(bus.swhbM, boff_s);
  assign ld_mis_s    = bus.memreadM & is_misaligned(bus.lwhbM, boff_s);
  assign misalign_s  = st_mis_s | ld_mis_s;
  assign store_acc_s = bus.memwriteM & ~st_mis_s & ~reset;
  assign mem_word_s  = mem_q[idx_s];

  // Store-buffer, fault-record and counter next state.
  always_comb begin
    pend_valid_d = 1'b0;
    pend_idx_d   = pend_idx_q;
    pend_be_d    = pend_be_q;
    pend_data_d  = pend_data_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    fault_pc_d   = fault_pc_q;
    store_cnt_d  = store_cnt_q;
    if (reset) begin
      // Pend fields are cleared too so nothing undefined can reach the forward path.
      pend_idx_d   = {AW{1'b0}};
      pend_be_d    = 4'b0000;
      pend_data_d  = {XLEN{1'b0}};
      fault_d      = 1'b0;
      fault_addr_d = {XLEN{1'b0}};
      fault_pc_d   = {XLEN{1'b0}};
      store_cnt_d  = 32'd0;
    end else begin
      if (store_acc_s) begin
        pend_valid_d = 1'b1;
        pend_idx_d   = idx_s;
        pend_be_d    = byte_en(bus.swhbM, boff_s);
        pend_data_d  = bus.writedataM << {boff_s, 3'b000};
        store_cnt_d  = store_cnt_q + 32'd1;
      end else begin
        pend_valid_d = 1'b0;
      end
      if (misalign_s && !fault_q) begin
        fault_d      = 1'b1;
        fault_addr_d = bus.aluoutM;
        fault_pc_d   = bus.pcM;
      end else begin
        fault_d      = fault_q;
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    pend_valid_q <= pend_valid_d;
    pend_idx_q   <= pend_idx_d;
    pend_be_q    <= pend_be_d;
    pend_data_q  <= pend_data_d;
    fault_q      <= fault_d;
    fault_addr_q <= fault_addr_d;
    fault_pc_q   <= fault_pc_d;
    store_cnt_q  <= store_cnt_d;
  end

  // Commit the buffered store; reset discards it instead.
  always_ff @(posedge clk) begin
    if (!reset && pend_valid_q) begin
      for (int i = 0; i < 4; i++) begin
        if (pend_be_q[i]) begin
          mem_q[pend_idx_q][8*i +: 8] <= pend_data_q[8*i +: 8];
        end
      end
    end
  end

  // Load path: merge buffered bytes, align, extend.
  always_comb begin
    fwd_word_s = mem_word_s;
    for (int i = 0; i < 4; i++) begin
      fwd_word_s[8*i +: 8] = (pend_valid_q && (pend_idx_q == idx_s) && pend_be_q[i]) ?
                             pend_data_q[8*i +: 8] : mem_word_s[8*i +: 8];
    end
    shifted_s = fwd_word_s >> {boff_s, 3'b000};
    case (bus.lwhbM)
      2'b01:   load_val_s = {{16{~bus.lunsignedM & shifted_s[15]}}, shifted_s[15:0]};
      2'b10:   load_val_s = {{24{~bus.lunsignedM & shifted_s[7]}}, shifted_s[7:0]};
      default: load_val_s = shifted_s;
    endcase
    if (bus.memreadM && !ld_mis_s) begin
      readdata_s = load_val_s;
    end else begin
      readdata_s = {XLEN{1'b0}};
    end
  end

  assign bus.readdataM  = readdata_s;
  assign bus.misalignM  = misalign_s;
  assign bus.faultS     = fault_q;
  assign bus.fault_addr = fault_addr_q;
  assign bus.fault_pc   = fault_pc_q;
  assign bus.store_cnt  = store_cnt_q;

endmodule
